// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared sizes, state encoding and helpers
// for the round-robin shared-multiplier arbiter.
package mult_arb_pkg;

   localparam int MULT_W      = 16;
   localparam int TIMEOUT_CYC = 63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ARM,
      ST_RUN,
      ST_FIN
   } state_e;

   // Bits needed to count from 0 up to limit inclusive.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mult_arb_rr_pick2.sv
// rr_pick2: two-way round-robin winner selection.
// A lone requester wins; on a tie the side that did not go last wins.
module rr_pick2
   import mult_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       any_o,
   output logic       win_o
);

   // Winner index from the request pair and the last-served side.
   always_comb begin
      any_o = |req_i;
      win_o = 1'b0;
      unique case (req_i)
         2'b01:   win_o = 1'b0;
         2'b10:   win_o = 1'b1;
         2'b11:   win_o = ~last_i;
         default: win_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mult_arb.sv
// mult_arb: shares one multiplier between two requesters,
// sequencing launch / busy-rise / busy-fall and returning the product.
module mult_arb
   import mult_arb_pkg::*;
#(
   parameter int W       = MULT_W,
   parameter int TIMEOUT = TIMEOUT_CYC
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] m0,
   input  logic [W-1:0] n0,
   input  logic [W-1:0] m1,
   input  logic [W-1:0] n1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] prod0,
   output logic [W-1:0] prod1,
   output logic         mult_start,
   output logic [W-1:0] mult_m,
   output logic [W-1:0] mult_n,
   input  logic [W-1:0] mult_prod,
   input  logic         mult_busy,
   output logic         err
);

   localparam int            CW       = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e          state_q;
   logic [1:0]      gnt_q;
   logic [1:0]      done_q;
   logic [W-1:0]    prod0_q;
   logic [W-1:0]    prod1_q;
   logic            start_q;
   logic [W-1:0]    m_q;
   logic [W-1:0]    n_q;
   logic            err_q;
   logic            last_q;
   logic [CW-1:0]   cnt_q;

   logic            any_d;
   logic            win_d;

   rr_pick2 u_pick (
      .req_i  ({req1, req0}),
      .last_i (last_q),
      .any_o  (any_d),
      .win_o  (win_d)
   );

   // Arbiter FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         prod0_q <= '0;
         prod1_q <= '0;
         start_q <= 1'b0;
         m_q     <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 2'b00;
         unique case (state_q)
            ST_IDLE: begin
               if (any_d && !mult_busy) begin
                  state_q <= ST_START;
                  last_q  <= win_d;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  m_q     <= win_d ? m1 : m0;
                  n_q     <= win_d ? n1 : n0;
                  start_q <= 1'b1;
               end
            end
            ST_START: begin
               cnt_q   <= '0;
               state_q <= ST_ARM;
            end
            ST_ARM: begin
               if (mult_busy) begin
                  state_q <= ST_RUN;
               end else if (cnt_q == CNT_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
                  done_q  <= gnt_q;
                  if (last_q) prod1_q <= '0;
                  else        prod0_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_RUN: begin
               if (!mult_busy) begin
                  state_q <= ST_FIN;
                  done_q  <= gnt_q;
                  if (last_q) prod1_q <= mult_prod;
                  else        prod0_q <= mult_prod;
               end
            end
            ST_FIN: begin
               gnt_q   <= 2'b00;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt0       = gnt_q[0];
   assign gnt1       = gnt_q[1];
   assign done0      = done_q[0];
   assign done1      = done_q[1];
   assign prod0      = prod0_q;
   assign prod1      = prod1_q;
   assign mult_start = start_q;
   assign mult_m     = m_q;
   assign mult_n     = n_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: directed and randomized checks of mult_arb
// against a multiplier model and an arbitration reference.
module tb_mult_arb;

   localparam int W  = 16;
   localparam int TO = 63;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] m0 = '0;
   logic [W-1:0] n0 = '0;
   logic [W-1:0] m1 = '0;
   logic [W-1:0] n1 = '0;
   logic         gnt0, gnt1, done0, done1;
   logic [W-1:0] prod0, prod1;
   logic         mult_start;
   logic [W-1:0] mult_m, mult_n, mult_prod;
   logic         mult_busy = 1'b0;
   logic         err;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           busy_len = 16;
   bit           no_busy = 1'b0;
   int           starts = 0;
   int           busy_left = 0;
   logic [W-1:0] prod_reg = '0;
   int           exp_last = 1;

   mult_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .req1       (req1),
      .m0         (m0),
      .n0         (n0),
      .m1         (m1),
      .n1         (n1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .done0      (done0),
      .done1      (done1),
      .prod0      (prod0),
      .prod1      (prod1),
      .mult_start (mult_start),
      .mult_m     (mult_m),
      .mult_n     (mult_n),
      .mult_prod  (mult_prod),
      .mult_busy  (mult_busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Multiplier model: busy for busy_len cycles starting the cycle after start.
   always @(posedge clk) begin
      if (mult_start && !no_busy) begin
         busy_left <= busy_len;
         mult_busy <= 1'b1;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else begin
         busy_left <= 0;
         mult_busy <= 1'b0;
      end
      if (mult_start) begin
         starts   <= starts + 1;
         prod_reg <= mult_m * mult_n;
      end
   end

   assign mult_prod = mult_busy ? 16'hDEAD : prod_reg;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      chk("gnt_excl", 32'(gnt0 & gnt1), 0);
      chk("done_side", 32'((done0 & !gnt0) | (done1 & !gnt1)), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 0);
      chk({tag, "_done"}, {30'd0, done1, done0}, 0);
      chk({tag, "_start"}, 32'(mult_start), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_prod0"}, 32'(prod0), 0);
      chk({tag, "_prod1"}, 32'(prod1), 0);
      chk({tag, "_mm"}, 32'(mult_m), 0);
      chk({tag, "_mn"}, 32'(mult_n), 0);
   endtask

   task automatic reset_dut(input string tag);
      rst = 1'b1;
      tick();
      chk_reset(tag);
      rst = 1'b0;
      exp_last = 1;
   endtask

   // One full operation with the current req levels; checks winner,
   // operands, latency, product and start count.
   task automatic do_op(input int b, input bit to, input bit scr,
                        input string tag, output int side);
      int           exp_side, tg, td, s0;
      logic [W-1:0] om, on;
      logic [31:0]  ep;
      if (req0 && !req1)      exp_side = 0;
      else if (req1 && !req0) exp_side = 1;
      else                    exp_side = 1 - exp_last;
      exp_last = exp_side;
      om = exp_side ? m1 : m0;
      on = exp_side ? n1 : n0;
      ep = to ? 32'd0 : ((32'(om) * 32'(on)) & 32'hFFFF);
      busy_len = b;
      no_busy = to;
      s0 = starts;
      side = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (gnt0 || gnt1) begin
            side = gnt1 ? 1 : 0;
            break;
         end
      end
      chk({tag, "_side"}, side, exp_side);
      if (side < 0) return;
      chk({tag, "_mm"}, 32'(mult_m), 32'(om));
      chk({tag, "_mn"}, 32'(mult_n), 32'(on));
      tg = cyc;
      if (scr) begin
         if (side == 1) begin m1 = W'($urandom); n1 = W'($urandom); end
         else begin m0 = W'($urandom); n0 = W'($urandom); end
      end
      td = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (side == 1 ? done1 : done0) begin
            td = cyc;
            break;
         end
      end
      chk({tag, "_lat"}, td - tg, to ? TO + 1 : b + 2);
      chk({tag, "_prod"}, 32'(side == 1 ? prod1 : prod0), ep);
      chk({tag, "_gnthold"}, 32'(side == 1 ? gnt1 : gnt0), 1);
      chk({tag, "_other"}, 32'(side == 1 ? gnt0 : gnt1), 0);
      chk({tag, "_starts"}, starts - s0, 1);
   endtask

   initial begin
      int s, c0, c1, hb, got;
      logic prev;

      // Reset values
      tick();
      reset_dut("rst0");

      // Single op, busy 16 cycles
      m0 = 7; n0 = 9; req0 = 1'b1;
      do_op(16, 1'b0, 1'b0, "single", s);
      chk("single_p63", 32'(prod0), 63);
      req0 = 1'b0;
      tick();

      // Tie right after reset
      reset_dut("rst1");
      m0 = 3; n0 = 4; m1 = 5; n1 = 6;
      req0 = 1'b1; req1 = 1'b1;
      do_op(5, 1'b0, 1'b0, "tie0", s);
      chk("tie_first", s, 0);
      chk("tie_p12", 32'(prod0), 12);
      req0 = 1'b0;
      do_op(5, 1'b0, 1'b0, "tie1", s);
      chk("tie_second", s, 1);
      chk("tie_p30", 32'(prod1), 30);

      // Fairness: both held for six ops
      req0 = 1'b1; req1 = 1'b1;
      c0 = 0; c1 = 0;
      for (int i = 0; i < 6; i++) begin
         do_op(int'($urandom_range(1, 6)), 1'b0, 1'b0, "fair", s);
         chk("fair_order", s, i % 2);
         if (s == 0) c0++;
         if (s == 1) c1++;
      end
      chk("fair_cnt0", c0, 3);
      chk("fair_cnt1", c1, 3);

      // Randomized requests, operands and busy lengths
      for (int i = 0; i < 12; i++) begin
         int pat;
         pat = int'($urandom_range(1, 3));
         req0 = pat[0]; req1 = pat[1];
         m0 = W'($urandom); n0 = W'($urandom);
         m1 = W'($urandom); n1 = W'($urandom);
         do_op(int'($urandom_range(1, 8)), 1'b0,
               1'($urandom_range(0, 1)), "rand", s);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // Operand stability after grant
      m0 = 16'hFFFF; n0 = 16'd2; req0 = 1'b1;
      do_op(3, 1'b0, 1'b1, "stab", s);
      chk("stab_fffe", 32'(prod0), 32'hFFFE);
      req0 = 1'b0;
      tick();

      // Timeout: busy never rises
      reset_dut("rst2");
      m0 = 9; n0 = 9; req0 = 1'b1;
      do_op(0, 1'b1, 1'b0, "tmo", s);
      chk("tmo_err", 32'(err), 1);
      req0 = 1'b0;
      tick(); tick(); tick();
      chk("tmo_sticky", 32'(err), 1);
      m1 = 2; n1 = 2; req1 = 1'b1;
      do_op(2, 1'b0, 1'b0, "after_tmo", s);
      chk("tmo_sticky2", 32'(err), 1);
      req1 = 1'b0;
      tick();
      reset_dut("rst3");

      // Reset mid-RUN while the multiplier stays busy
      m0 = 2; n0 = 3; req0 = 1'b1;
      busy_len = 30; no_busy = 1'b0;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (gnt0) begin got = 1; break; end
      end
      chk("mid_grant0", got, 1);
      for (int i = 0; i < 6; i++) tick();
      req0 = 1'b0; req1 = 1'b1;
      m1 = 11; n1 = 13;
      rst = 1'b1;
      tick();
      chk_reset("mid_rst");
      chk("mid_busy", 32'(mult_busy), 1);
      rst = 1'b0;
      exp_last = 1;
      busy_len = 4;
      hb = 0; got = 0;
      prev = mult_busy;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (gnt1) begin got = 1; break; end
         if (mult_busy) hb++;
         chk("mid_nodone", {30'd0, done1, done0}, 0);
         prev = mult_busy;
      end
      chk("mid_grant1", got, 1);
      chk("mid_prevbusy", 32'(prev), 0);
      chk("mid_heldoff", 32'(hb >= 5), 1);
      got = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done1) begin got = 1; break; end
      end
      chk("mid_done1", got, 1);
      chk("mid_p143", 32'(prod1), 143);
      req1 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
